ifmap_stream_feeder: RTL
========================

Name: ifmap_stream_feeder

Overview:
- Producer side of the PE IFmap input buffer protocol.
- Fetches raw IFmap activations row by row from a synchronous source memory (1-cycle read latency).
- Tags each word with start/end status bits and pushes it into the IFmap circular buffer through its write_enable/ready/full handshake.
- Sits between the global activation memory and each PE's IFmap buffer; one instance per PE.

Parameters:
- IFMAP_BUFFER_WIDTH, 8, buffer word width: bit [W-1] = start, bit [W-2] = end, bits [W-3:0] = data.
- IFMAP_SPAD_WIDTH, 6, activation data width; must equal IFMAP_BUFFER_WIDTH-2.
- SRC_ADDR_WIDTH, 10, source memory address width.
- ROW_LEN_WIDTH, 6, width of the row-length field.
- ROW_CNT_WIDTH, 6, width of the row-count field.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset (asserted at 0).
- start, input, 1, pulse; latches base_addr/row_len/row_cnt; ignored while busy.
- base_addr, input, SRC_ADDR_WIDTH, first source address.
- row_len, input, ROW_LEN_WIDTH, words per row; must be >= 1.
- row_cnt, input, ROW_CNT_WIDTH, number of rows; must be >= 1.
- src_ren, output, 1, source read strobe.
- src_addr, output, SRC_ADDR_WIDTH, source read address.
- src_dout, input, IFMAP_SPAD_WIDTH, source data, valid the cycle after src_ren.
- buffer_din, output, IFMAP_BUFFER_WIDTH, tagged word to the IFmap buffer.
- buffer_write_enable, output, 1, write strobe.
- buffer_ready, input, 1, buffer can accept a word this cycle.
- buffer_full, input, 1, buffer full.
- busy, output, 1, transfer in progress.
- done, output, 1, one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; src_ren=0, src_addr=0, buffer_din=0, buffer_write_enable=0, busy=0, done=0; internal counters and holding register cleared. Reset mid-transfer aborts the transfer immediately; no partial word is written after reset.
- Transfer setup: latched row_len/row_cnt are held constant for the whole transfer. Address increments by 1 per word across rows (rows contiguous).
- Tagging:
  - start bit = 1 for column index 0.
  - end bit = 1 for column index row_len-1.
  - row_len=1 sets both bits (status 2'b11).
  - data field = src_dout, zero-extended if narrower.
- Write acceptance: a write is accepted only when buffer_write_enable && buffer_ready && !buffer_full. buffer_write_enable may only assert when the accept condition holds; otherwise the word stays in the holding register, with buffer_din stable.
- FSM (baseline):
  - IDLE: on start go to FETCH; busy goes 1 the next cycle.
  - FETCH: src_ren=1 with current address; go to CAPTURE.
  - CAPTURE: load src_dout into the holding register with tags; go to PUSH.
  - PUSH: when the accept condition holds, write one cycle. Then if more words remain, increment column (wrap to 0 and increment row at row_len-1) and go to FETCH; else go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Throughput (baseline): 3 cycles per word with buffer ready.
- Latency: start to first buffer_write_enable = 3 cycles (FETCH, CAPTURE, PUSH).
- Stall: buffer_full or !buffer_ready during PUSH holds state indefinitely; no source reads are issued while stalled.
- start asserted while busy: ignored; latched parameters unchanged.
- Total words = row_len*row_cnt, computed at full width (ROW_LEN_WIDTH+ROW_CNT_WIDTH bits). Source address wraps modulo 2^SRC_ADDR_WIDTH.

Optional Feature:
- Macro: IFMAP_FEEDER_PREFETCH_EN.
- When defined:
  - Adds a 2-entry skid queue; reads are issued every cycle while the queue has a free slot, counting in-flight reads.
  - Sustains 1 word/cycle; start-to-first-write latency is 2 cycles.
  - Words are written in address order with identical tagging.
  - Stall never loses an in-flight word.
  - done pulses after the last accepted write, with the queue empty.
- When undefined: baseline 3-cycle FSM above, with no skid queue logic.

Test Plan:
- Row start/end tagging: start, base_addr=0, row_len=3, row_cnt=2, memory[i]=i+1, buffer always ready -> buffer_din sequence 0x81,0x02,0x43,0x84,0x05,0x46; done pulses once; busy deasserts with done.
- Single-word row: row_len=1, row_cnt=2, memory[0]=5, memory[1]=9 -> buffer_din 0xC5,0xC9.
- Backpressure: buffer_full=1 for 10 cycles mid-transfer -> no buffer_write_enable and no src_ren while full; sequence unchanged after release; no duplicate or lost words.
- Reset mid-operation: rst=0 during PUSH of word 2 -> all outputs 0 asynchronously; a new start after release restarts from base_addr with the start bit set.
- Start while busy: start pulse during transfer with different base_addr -> ignored; original sequence completes.
- Throughput: row_len=4, row_cnt=1, buffer always ready -> with IFMAP_FEEDER_PREFETCH_EN, 4 consecutive write cycles; without it, writes exactly 3 cycles apart.

Source files
------------

// File: rtl/ifmap_stream_feeder.sv
// Streams IFmap rows from source memory into a PE IFmap buffer with start/end tags.
// Define IFMAP_FEEDER_PREFETCH_EN for the 1 word/cycle skid-queue variant.
module ifmap_stream_feeder #(
   parameter int IFMAP_BUFFER_WIDTH = 8,
   parameter int IFMAP_SPAD_WIDTH   = 6,
   parameter int SRC_ADDR_WIDTH     = 10,
   parameter int ROW_LEN_WIDTH      = 6,
   parameter int ROW_CNT_WIDTH      = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [SRC_ADDR_WIDTH-1:0]     base_addr,
   input  logic [ROW_LEN_WIDTH-1:0]      row_len,
   input  logic [ROW_CNT_WIDTH-1:0]      row_cnt,
   output logic                          src_ren,
   output logic [SRC_ADDR_WIDTH-1:0]     src_addr,
   input  logic [IFMAP_SPAD_WIDTH-1:0]   src_dout,
   output logic [IFMAP_BUFFER_WIDTH-1:0] buffer_din,
   output logic                          buffer_write_enable,
   input  logic                          buffer_ready,
   input  logic                          buffer_full,
   output logic                          busy,
   output logic                          done
);

   localparam int DW = IFMAP_BUFFER_WIDTH - 2;

   logic                      accept_ok;
   logic [ROW_LEN_WIDTH-1:0]  len_q;
   logic [ROW_LEN_WIDTH-1:0]  col_q;
   logic [SRC_ADDR_WIDTH-1:0] addr_q;
   logic [DW-1:0]             data_ext;
   logic                      col_first;
   logic                      col_last;

   assign accept_ok = buffer_ready && !buffer_full;
   assign col_first = (col_q == '0);
   assign col_last  = (col_q == len_q - ROW_LEN_WIDTH'(1));
   assign src_addr  = addr_q;

   always_comb begin
      data_ext = '0;
      data_ext[IFMAP_SPAD_WIDTH-1:0] = src_dout;
   end

`ifndef IFMAP_FEEDER_PREFETCH_EN

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_PUSH,
      S_DONE
   } state_t;

   state_t                        state_q;
   state_t                        state_d;
   logic [ROW_CNT_WIDTH-1:0]      cnt_q;
   logic [ROW_CNT_WIDTH-1:0]      row_q;
   logic [IFMAP_BUFFER_WIDTH-1:0] hold_q;
   logic                          last_word;

   assign last_word  = col_last && (row_q == cnt_q - ROW_CNT_WIDTH'(1));
   assign buffer_din = hold_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d             = state_q;
      src_ren             = 1'b0;
      buffer_write_enable = 1'b0;
      busy                = 1'b0;
      done                = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            busy    = 1'b1;
            src_ren = 1'b1;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            busy    = 1'b1;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            busy = 1'b1;
            if (accept_ok) begin
               buffer_write_enable = 1'b1;
               state_d = last_word ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q  <= '0;
         cnt_q  <= '0;
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
         hold_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            len_q  <= row_len;
            cnt_q  <= row_cnt;
            addr_q <= base_addr;
            col_q  <= '0;
            row_q  <= '0;
         end
         if (state_q == S_CAPTURE) begin
            hold_q <= {col_first, col_last, data_ext};
         end
         if (state_q == S_PUSH && accept_ok) begin
            addr_q <= addr_q + SRC_ADDR_WIDTH'(1);
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + ROW_CNT_WIDTH'(1);
            end else begin
               col_q <= col_q + ROW_LEN_WIDTH'(1);
            end
         end
      end
   end

`else

   localparam int TW = ROW_LEN_WIDTH + ROW_CNT_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                        state_q;
   state_t                        state_d;
   logic [IFMAP_BUFFER_WIDTH-1:0] q_mem [2];
   logic                          q_head_q;
   logic                          q_tail_q;
   logic [1:0]                    q_cnt_q;
   logic                          pend_q;
   logic [1:0]                    pend_tag_q;
   logic [TW-1:0]                 rd_left_q;
   logic [TW-1:0]                 wr_left_q;
   logic                          q_empty;
   logic                          have_word;
   logic                          pop;
   logic                          issue;
   logic                          q_push;
   logic                          q_pop;
   logic [2:0]                    occ;
   logic [IFMAP_BUFFER_WIDTH-1:0] pend_word;

   // pend_q marks a read whose data is on src_dout this cycle
   assign q_empty   = (q_cnt_q == 2'd0);
   assign pend_word = {pend_tag_q, data_ext};
   assign have_word = !q_empty || pend_q;
   assign occ       = {1'b0, q_cnt_q} + {2'b00, pend_q};
   assign q_pop     = pop && !q_empty;
   assign q_push    = pend_q && !(pop && q_empty);

   always_comb begin
      buffer_din = '0;
      if (!q_empty)   buffer_din = q_mem[q_head_q];
      else if (pend_q) buffer_din = pend_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d             = state_q;
      src_ren             = 1'b0;
      buffer_write_enable = 1'b0;
      busy                = 1'b0;
      done                = 1'b0;
      pop                 = 1'b0;
      issue               = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            busy  = 1'b1;
            pop   = have_word && accept_ok;
            issue = (rd_left_q != '0) && accept_ok && (occ < 3'd2);
            src_ren             = issue;
            buffer_write_enable = pop;
            if (pop && wr_left_q == TW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         rd_left_q  <= '0;
         wr_left_q  <= '0;
         pend_q     <= 1'b0;
         pend_tag_q <= '0;
         q_head_q   <= 1'b0;
         q_tail_q   <= 1'b0;
         q_cnt_q    <= '0;
         q_mem[0]   <= '0;
         q_mem[1]   <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            len_q     <= row_len;
            addr_q    <= base_addr;
            col_q     <= '0;
            rd_left_q <= TW'(row_len) * TW'(row_cnt);
            wr_left_q <= TW'(row_len) * TW'(row_cnt);
         end
         pend_q <= issue;
         if (issue) begin
            pend_tag_q <= {col_first, col_last};
            addr_q     <= addr_q + SRC_ADDR_WIDTH'(1);
            rd_left_q  <= rd_left_q - TW'(1);
            col_q      <= col_last ? '0 : col_q + ROW_LEN_WIDTH'(1);
         end
         if (pop) wr_left_q <= wr_left_q - TW'(1);
         if (q_push) begin
            q_mem[q_tail_q] <= pend_word;
            q_tail_q        <= ~q_tail_q;
         end
         if (q_pop) q_head_q <= ~q_head_q;
         if (q_push && !q_pop)      q_cnt_q <= q_cnt_q + 2'd1;
         else if (q_pop && !q_push) q_cnt_q <= q_cnt_q - 2'd1;
      end
   end

`endif

endmodule
